// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for a bank of N W-bit registers.
// Two requesters share the bank's write port with round-robin priority,
// and a bank-wide clear writes zero to every register, one per cycle.
// All outputs are registered: a decision made at an edge is visible on
// gnt/wen/wdata for the cycle that follows that edge.
module regbank_write_arbiter #(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [W-1:0]  data0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [W-1:0]  data1,
  input  logic          clr_req,
  output logic          gnt0,
  output logic          gnt1,
  output logic [N-1:0]  wen,
  output logic [W-1:0]  wdata,
  output logic          clr_busy
);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_idx;     // index of the clear write currently on wen
  logic          r_last_grant;  // port that received the most recent grant
  logic          r_gnt0;
  logic          r_gnt1;
  logic [N-1:0]  r_wen;
  logic [W-1:0]  r_wdata;
  logic          r_clr_busy;

  logic          w_elig0;
  logic          w_elig1;
  logic          w_pick1;
  logic          w_clr_last;
  logic [AW-1:0] w_clr_next;

  // A request held high through its own grant cycle is the tail of the
  // handshake just served, not a new request.
  assign w_elig0 = req0 & ~r_gnt0;
  assign w_elig1 = req1 & ~r_gnt1;

  // Port 1 wins when it is the only one asking, or on a tie when port 0
  // was served last.
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  // Completion is an explicit compare against N-1, never a wrap test.
  assign w_clr_last = (r_clr_idx == AW'(N - 1));
  assign w_clr_next = r_clr_idx + AW'(1);

  // Arbitration / clear sequencer with registered outputs.
  // NOTE: every state element here is assigned with <= so all of them
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB;
      r_clr_idx    <= '0;
      r_last_grant <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_wen        <= '0;
      r_wdata      <= '0;
      r_clr_busy   <= 1'b0;
    end else begin
      // Grants and enables are single-cycle pulses unless re-issued below.
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_wen  <= '0;
      case (r_state)
        ARB: begin
          if (clr_req) begin
            // First clear write goes out immediately; pending requests wait.
            r_state    <= CLEAR;
            r_clr_idx  <= '0;
            r_wen      <= N'(1);
            r_wdata    <= '0;
            r_clr_busy <= 1'b1;
          end else if (w_elig0 || w_elig1) begin
            r_last_grant <= w_pick1;
            if (w_pick1) begin
              r_gnt1  <= 1'b1;
              r_wen   <= N'(1) << addr1;
              r_wdata <= data1;
            end else begin
              r_gnt0  <= 1'b1;
              r_wen   <= N'(1) << addr0;
              r_wdata <= data0;
            end
          end
        end
        CLEAR: begin
          if (w_clr_last) begin
            // One idle cycle after the last clear write; wdata holds 0.
            r_state    <= ARB;
            r_clr_busy <= 1'b0;
          end else begin
            r_clr_idx  <= w_clr_next;
            r_wen      <= N'(1) << w_clr_next;
            r_wdata    <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        default: begin
          r_state    <= ARB;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign wen      = r_wen;
  assign wdata    = r_wdata;
  assign clr_busy = r_clr_busy;

endmodule
